vgc_bram_arb: RTL and testbench

- Shares the single 32-bit VGC blockram read port between two requesters.
- Port 0 is the SHR framebuffer renderer. It assumes fixed-latency reads and is never stalled.
- Port 1 is a secondary requester, e.g. a border/debug overlay fetcher or a palette prefetcher. It uses a request/grant handshake.
- Sits between the renderers and the blockram port of apple_memory. Also owns the VGC-active routing signal, including a drain phase on deactivation.

---
 rtl/vgc_bram_arb.sv | 123 ++++++++++++
 tb/tb_vgc_bram_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vgc_bram_arb.sv
// vgc_bram_arb: shares the VGC blockram read port between a fixed-latency renderer and a handshaked requester
// Ports:
//   clk_logic, system_reset_n        54 MHz clock, synchronous active-low reset
//   active_i / bram_active_o         SHR mode request / aux BRAM routed to VGC (held through drain)
//   bram_rd_o, bram_addr_o           registered read strobe and address to BRAM
//   bram_data_i                      BRAM read data, valid BRAM_LATENCY cycles after the strobe
//   p0_rd_i, p0_addr_i               port 0 fire-and-forget read, highest priority, never stalled
//   p0_data_o, p0_valid_o            port 0 return data and strobe
//   p1_rd_i, p1_addr_i, p1_gnt_o     port 1 level request, address and combinational grant
//   p1_data_o, p1_valid_o            port 1 return data and strobe
//   p0_drop_o                        sticky: port 0 read arrived while not ACTIVE
// Optional: define VGC_BRAM_ARB_STATS_EN to add stats_clr_i, p1_wait_cnt_o, p1_max_wait_o.
module vgc_bram_arb #(
    parameter int BRAM_LATENCY = 1,
    parameter int ADDR_W = 13
) (
    input  logic              clk_logic,
    input  logic              system_reset_n,
`ifdef VGC_BRAM_ARB_STATS_EN
    input  logic              stats_clr_i,
    output logic [15:0]       p1_wait_cnt_o,
    output logic [15:0]       p1_max_wait_o,
`endif
    input  logic              active_i,
    output logic              bram_active_o,
    output logic              bram_rd_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    input  logic [31:0]       bram_data_i,
    input  logic              p0_rd_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    output logic [31:0]       p0_data_o,
    output logic              p0_valid_o,
    input  logic              p1_rd_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    output logic              p1_gnt_o,
    output logic [31:0]       p1_data_o,
    output logic              p1_valid_o,
    output logic              p0_drop_o
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
    state_e state_q, state_d;
    logic act, p0_acc, p1_acc;
    logic rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Tag pipeline: tv = read in flight, tp = owner (1 = port 1); the last stage lines up with bram_data_i
    logic [BRAM_LATENCY:0] tv_q, tv_d, tp_q, tp_d;
    logic [31:0] p0_data_q, p0_data_d, p1_data_q, p1_data_d;
    logic p0_valid_q, p0_valid_d, p1_valid_q, p1_valid_d, drop_q, drop_d;
    always_comb begin
        act = state_q == ACTIVE;
        p0_acc = act && p0_rd_i;
        p1_acc = act && !p0_rd_i && p1_rd_i;
        // Drain keeps the routing held until every in-flight tag has left the pipeline
        state_d = active_i ? ACTIVE : (act || (state_q == DRAIN && |tv_q)) ? DRAIN : IDLE;
        rd_d = p0_acc || p1_acc;
        addr_d = p0_acc ? p0_addr_i : p1_acc ? p1_addr_i : addr_q;
        tv_d = {tv_q[BRAM_LATENCY-1:0], rd_d};
        tp_d = {tp_q[BRAM_LATENCY-1:0], p1_acc};
        p0_valid_d = tv_q[BRAM_LATENCY] && !tp_q[BRAM_LATENCY];
        p1_valid_d = tv_q[BRAM_LATENCY] && tp_q[BRAM_LATENCY];
        p0_data_d = p0_valid_d ? bram_data_i : p0_data_q;
        p1_data_d = p1_valid_d ? bram_data_i : p1_data_q;
        drop_d = drop_q || (p0_rd_i && !act);
    end
    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            state_q <= IDLE;
            rd_q <= 1'b0;
            addr_q <= '0;
            tv_q <= '0;
            tp_q <= '0;
            p0_data_q <= '0;
            p1_data_q <= '0;
            p0_valid_q <= 1'b0;
            p1_valid_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q <= rd_d;
            addr_q <= addr_d;
            tv_q <= tv_d;
            tp_q <= tp_d;
            p0_data_q <= p0_data_d;
            p1_data_q <= p1_data_d;
            p0_valid_q <= p0_valid_d;
            p1_valid_q <= p1_valid_d;
            drop_q <= drop_d;
        end
    end
    assign bram_active_o = state_q != IDLE;
    assign bram_rd_o = rd_q;
    assign bram_addr_o = addr_q;
    assign p0_data_o = p0_data_q;
    assign p0_valid_o = p0_valid_q;
    assign p1_data_o = p1_data_q;
    assign p1_valid_o = p1_valid_q;
    assign p1_gnt_o = p1_acc;
    assign p0_drop_o = drop_q;
`ifdef VGC_BRAM_ARB_STATS_EN
    logic p1_wait;
    logic [15:0] wcnt_q, wcnt_d, wmax_q, wmax_d, wcur_q, wcur_d;
    always_comb begin
        p1_wait = act && p1_rd_i && p0_rd_i;
        wcnt_d = stats_clr_i ? 16'd0 : (p1_wait && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
        // wcur is the length of the current uninterrupted wait; it restarts once the wait ends
        wcur_d = (stats_clr_i || !p1_wait) ? 16'd0 : (wcur_q != 16'hFFFF) ? wcur_q + 16'd1 : wcur_q;
        wmax_d = stats_clr_i ? 16'd0 : (wcur_d > wmax_q) ? wcur_d : wmax_q;
    end
    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            wcnt_q <= '0;
            wcur_q <= '0;
            wmax_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            wcur_q <= wcur_d;
            wmax_q <= wmax_d;
        end
    end
    assign p1_wait_cnt_o = wcnt_q;
    assign p1_max_wait_o = wmax_q;
`endif
endmodule

// File: tb/tb_vgc_bram_arb.sv
// tb_vgc_bram_arb: directed scoreboard bench for vgc_bram_arb (BRAM_LATENCY = 1)
module tb_vgc_bram_arb;
    localparam int LAT = 1;
    localparam int AW = 13;
    logic clk_logic, system_reset_n, active_i, bram_active_o, bram_rd_o;
    logic [AW-1:0] bram_addr_o, p0_addr_i, p1_addr_i;
    logic [31:0] bram_data_i, p0_data_o, p1_data_o;
    logic p0_rd_i, p0_valid_o, p1_rd_i, p1_gnt_o, p1_valid_o, p0_drop_o;
`ifdef VGC_BRAM_ARB_STATS_EN
    logic stats_clr_i;
    logic [15:0] p1_wait_cnt_o, p1_max_wait_o;
`endif
    vgc_bram_arb #(.BRAM_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n),
`ifdef VGC_BRAM_ARB_STATS_EN
        .stats_clr_i(stats_clr_i), .p1_wait_cnt_o(p1_wait_cnt_o), .p1_max_wait_o(p1_max_wait_o),
`endif
        .active_i(active_i), .bram_active_o(bram_active_o), .bram_rd_o(bram_rd_o),
        .bram_addr_o(bram_addr_o), .bram_data_i(bram_data_i),
        .p0_rd_i(p0_rd_i), .p0_addr_i(p0_addr_i), .p0_data_o(p0_data_o), .p0_valid_o(p0_valid_o),
        .p1_rd_i(p1_rd_i), .p1_addr_i(p1_addr_i), .p1_gnt_o(p1_gnt_o), .p1_data_o(p1_data_o),
        .p1_valid_o(p1_valid_o), .p0_drop_o(p0_drop_o)
    );
    typedef struct {logic port; logic [31:0] data; int due;} exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0, cnt = 0;
    initial begin
        clk_logic = 1'b0;
        forever #5 clk_logic = ~clk_logic;
    end
    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return (a == 13'd8000) ? 32'hA5A5_1234 : {a, 6'h2A, a};
    endfunction
    // BRAM model: data for a strobe seen in cycle k is presented during cycle k+1
    initial begin
        logic pend;
        logic [AW-1:0] paddr;
        pend = 1'b0;
        paddr = '0;
        bram_data_i = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk_logic);
            #1;
            bram_data_i = pend ? mem(paddr) : 32'hDEAD_BEEF;
            pend = bram_rd_o;
            paddr = bram_addr_o;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic port, input logic [AW-1:0] a);
        sbq.push_back('{port, mem(a), cnt + LAT + 2});
    endtask
    task automatic sb_check();
        exp_t e;
        if (p0_valid_o || p1_valid_o) begin
            if (sbq.size() == 0) chk("sb_unexpected", {30'd0, p1_valid_o, p0_valid_o}, 32'd0);
            else begin
                e = sbq.pop_front();
                chk("sb_port", {30'd0, p1_valid_o, p0_valid_o}, e.port ? 32'd2 : 32'd1);
                chk("sb_data", e.port ? p1_data_o : p0_data_o, e.data);
                chk("sb_cycle", cnt, e.due);
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cnt) begin
            e = sbq.pop_front();
            chk("sb_missing", {30'd0, p1_valid_o, p0_valid_o}, e.port ? 32'd2 : 32'd1);
        end
    endtask
    task automatic cyc();
        @(posedge clk_logic);
        #1;
        cnt++;
        sb_check();
    endtask
    initial begin
        system_reset_n = 1'b0;
        active_i = 1'b0;
        p0_rd_i = 1'b0;
        p1_rd_i = 1'b0;
        p0_addr_i = '0;
        p1_addr_i = '0;
`ifdef VGC_BRAM_ARB_STATS_EN
        stats_clr_i = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst_bram_active", bram_active_o, 0);
        chk("rst_bram_rd", bram_rd_o, 0);
        chk("rst_bram_addr", bram_addr_o, 0);
        chk("rst_p0", {p0_valid_o, p0_data_o == 0, p0_drop_o}, 3'b010);
        chk("rst_p1", {p1_valid_o, p1_data_o == 0, p1_gnt_o}, 3'b010);
        system_reset_n = 1'b1;
        active_i = 1'b1;
        cyc();
        chk("active_on", bram_active_o, 1);
        // single port 0 read
        p0_rd_i = 1'b1;
        p0_addr_i = 13'd8000;
        push(0, 13'd8000);
        cyc();
        p0_rd_i = 1'b0;
        chk("t1_rd", bram_rd_o, 1);
        chk("t1_addr", bram_addr_o, 8000);
        cyc();
        cyc();
        chk("t1_p0_valid", p0_valid_o, 1);
        chk("t1_p0_data", p0_data_o, 32'hA5A5_1234);
        chk("t1_p1_valid", p1_valid_o, 0);
        chk("t1_p1_data_hold", p1_data_o, 0);
        cyc();
        // simultaneous p0/p1
        p0_rd_i = 1'b1;
        p0_addr_i = 13'd10;
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd20;
        push(0, 13'd10);
        #1;
        chk("t2_gnt_blocked", p1_gnt_o, 0);
        cyc();
        p0_rd_i = 1'b0;
        #1;
        chk("t2_gnt", p1_gnt_o, 1);
        chk("t2_addr0", bram_addr_o, 10);
        push(1, 13'd20);
        cyc();
        p1_rd_i = 1'b0;
        chk("t2_addr1", bram_addr_o, 20);
        chk("t2_rd1", bram_rd_o, 1);
        repeat (4) cyc();
        // 40-cycle port 0 burst with port 1 held
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd77;
        for (int i = 0; i < 40; i++) begin
            p0_rd_i = 1'b1;
            p0_addr_i = AW'(i);
            push(0, AW'(i));
            #1;
            chk("t3_burst_gnt", p1_gnt_o, 0);
            cyc();
        end
        p0_rd_i = 1'b0;
        #1;
        chk("t3_gnt_after", p1_gnt_o, 1);
        push(1, 13'd77);
        cyc();
        p1_rd_i = 1'b0;
        repeat (4) cyc();
        // deactivate with two reads in flight
        p0_rd_i = 1'b1;
        p0_addr_i = 13'd100;
        push(0, 13'd100);
        cyc();
        p0_addr_i = 13'd101;
        active_i = 1'b0;
        push(0, 13'd101);
        cyc();
        p0_rd_i = 1'b0;
        chk("t4_drain_active", bram_active_o, 1);
        p0_rd_i = 1'b1;
        p0_addr_i = 13'd5;
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd6;
        #1;
        chk("t4_drain_gnt", p1_gnt_o, 0);
        cyc();
        p0_rd_i = 1'b0;
        p1_rd_i = 1'b0;
        chk("t4_drop", p0_drop_o, 1);
        chk("t4_no_strobe", bram_rd_o, 0);
        chk("t4_active_pre", bram_active_o, 1);
        cyc();
        chk("t4_last_valid", p0_valid_o, 1);
        chk("t4_active_last", bram_active_o, 1);
        cyc();
        chk("t4_idle", bram_active_o, 0);
        // reset with two reads in flight
        active_i = 1'b1;
        cyc();
        p0_rd_i = 1'b1;
        p0_addr_i = 13'd200;
        cyc();
        p0_rd_i = 1'b0;
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd300;
        cyc();
        p1_rd_i = 1'b0;
        system_reset_n = 1'b0;
        cyc();
        system_reset_n = 1'b1;
        active_i = 1'b0;
        chk("t5_outs", {bram_active_o, bram_rd_o, p0_valid_o, p1_valid_o, p0_drop_o}, 0);
        chk("t5_addr", bram_addr_o, 0);
        chk("t5_data", p0_data_o | p1_data_o, 0);
        repeat (4) cyc();
        p0_rd_i = 1'b1;
        cyc();
        p0_rd_i = 1'b0;
        chk("t5_idle_drop", p0_drop_o, 1);
        chk("t5_idle_nostrobe", bram_rd_o, 0);
        repeat (3) cyc();
`ifdef VGC_BRAM_ARB_STATS_EN
        active_i = 1'b1;
        stats_clr_i = 1'b1;
        cyc();
        stats_clr_i = 1'b0;
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd400;
        for (int i = 0; i < 5; i++) begin
            p0_rd_i = 1'b1;
            p0_addr_i = AW'(500 + i);
            push(0, AW'(500 + i));
            cyc();
        end
        p0_rd_i = 1'b0;
        push(1, 13'd400);
        cyc();
        p1_rd_i = 1'b0;
        cyc();
        p1_rd_i = 1'b1;
        p1_addr_i = 13'd401;
        for (int i = 0; i < 3; i++) begin
            p0_rd_i = 1'b1;
            p0_addr_i = AW'(600 + i);
            push(0, AW'(600 + i));
            cyc();
        end
        p0_rd_i = 1'b0;
        push(1, 13'd401);
        cyc();
        p1_rd_i = 1'b0;
        chk("st_wait_cnt", p1_wait_cnt_o, 8);
        chk("st_max_wait", p1_max_wait_o, 5);
        stats_clr_i = 1'b1;
        cyc();
        stats_clr_i = 1'b0;
        chk("st_clr", {p1_wait_cnt_o, p1_max_wait_o}, 0);
        repeat (4) cyc();
`endif
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
